// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner.
// Drives one row at a time, samples the synchronized columns at the end of
// each row dwell, and reports a single accepted key with a one-cycle strobe.
// Optional feature macro: KEYPAD_DEBOUNCE_EN
//   defined   -> press and release must be stable for DEBOUNCE_CYCLES samples
//   undefined -> no debounce counters; accept on the first valid sample and
//                release on the first all-zero column sample
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic       strobe,
  output logic [7:0] cur_key,
  output logic       key_down
);

  localparam int            DW         = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t        state_reg;
  logic [3:0]    col_meta_reg;
  logic [3:0]    colsync;
  logic [DW-1:0] dwell_reg;
  logic [3:0]    rows_reg;
  logic          strobe_reg;
  logic [7:0]    cur_key_reg;
  logic          key_down_reg;
  logic          col_single;
  logic          col_zero;

`ifdef KEYPAD_DEBOUNCE_EN
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] deb_cnt_reg;
  logic [CW-1:0] rel_cnt_reg;
  logic [7:0]    cap_key_reg;
`endif

  // Out-of-range parameters elaborate a visibly named block for inspection.
  generate
    if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_out_of_range
    end
  endgenerate

  // Exactly one column bit set: x != 0 and x & (x-1) == 0.
  assign col_single = (colsync != 4'd0) && ((colsync & (colsync - 4'd1)) == 4'd0);
  assign col_zero   = (colsync == 4'd0);

  assign rows     = rows_reg;
  assign strobe   = strobe_reg;
  assign cur_key  = cur_key_reg;
  assign key_down = key_down_reg;

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      col_meta_reg <= 4'd0;
      colsync      <= 4'd0;
    end else begin
      col_meta_reg <= columns;
      colsync      <= col_meta_reg;
    end
  end

  // Scan / debounce / held state machine with registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= SCAN;
      dwell_reg    <= '0;
      rows_reg     <= 4'b1000;
      strobe_reg   <= 1'b0;
      cur_key_reg  <= 8'h00;
      key_down_reg <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      deb_cnt_reg  <= '0;
      rel_cnt_reg  <= '0;
      cap_key_reg  <= 8'h00;
`endif
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        SCAN: begin
          if (dwell_reg != DWELL_LAST) begin
            dwell_reg <= dwell_reg + DW'(1);
          end else if (col_single) begin
`ifdef KEYPAD_DEBOUNCE_EN
            cap_key_reg <= {rows_reg, colsync};
            deb_cnt_reg <= '0;
            state_reg   <= DEBOUNCE;
`else
            cur_key_reg  <= {rows_reg, colsync};
            strobe_reg   <= 1'b1;
            key_down_reg <= 1'b1;
            state_reg    <= HELD;
`endif
          end else begin
            rows_reg  <= {rows_reg[0], rows_reg[3:1]};
            dwell_reg <= '0;
          end
        end

        DEBOUNCE: begin
`ifdef KEYPAD_DEBOUNCE_EN
          if (colsync != cap_key_reg[3:0]) begin
            // Bounce: rescan the same row from the start of its dwell.
            dwell_reg <= '0;
            state_reg <= SCAN;
          end else if (deb_cnt_reg == CNT_LAST) begin
            cur_key_reg  <= cap_key_reg;
            strobe_reg   <= 1'b1;
            key_down_reg <= 1'b1;
            rel_cnt_reg  <= '0;
            state_reg    <= HELD;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + CW'(1);
          end
`else
          dwell_reg <= '0;
          state_reg <= SCAN;
`endif
        end

        HELD: begin
`ifdef KEYPAD_DEBOUNCE_EN
          if (!col_zero) begin
            // Any activity, including a different column, restarts release.
            rel_cnt_reg <= '0;
          end else if (rel_cnt_reg == CNT_LAST) begin
            key_down_reg <= 1'b0;
            rows_reg     <= {rows_reg[0], rows_reg[3:1]};
            dwell_reg    <= '0;
            state_reg    <= SCAN;
          end else begin
            rel_cnt_reg <= rel_cnt_reg + CW'(1);
          end
`else
          if (col_zero) begin
            key_down_reg <= 1'b0;
            rows_reg     <= {rows_reg[0], rows_reg[3:1]};
            dwell_reg    <= '0;
            state_reg    <= SCAN;
          end
`endif
        end

        default: begin
          dwell_reg <= '0;
          state_reg <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: table-driven key presses, hand-written corner cases and
// randomized column activity, all checked against a behavioural model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [3:0] columns = 4'd0;
  logic [3:0] rows;
  logic       strobe;
  logic [7:0] cur_key;
  logic       key_down;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .columns  (columns),
    .rows     (rows),
    .strobe   (strobe),
    .cur_key  (cur_key),
    .key_down (key_down)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The scanner is described by which row is being looked at, how far into
  // that row's dwell time we are, and how long the current press/release has
  // been stable. Column values reach the decision logic two clocks late.
  typedef enum int {M_SCAN, M_DEB, M_HELD} m_mode_t;
  m_mode_t    m_mode;
  int         m_row;      // 0..3 -> R0..R3
  int         m_phase;    // cycles spent on the current row
  int         m_run;      // stable samples counted so far
  logic [3:0] m_late1, m_late2;
  logic [3:0] m_cap_row, m_cap_col;
  logic       m_strobe, m_kd;
  logic [7:0] m_key;
  int         m_strobe_total = 0;

  function automatic logic [3:0] row_code(input int r);
    logic [3:0] base;
    base = 4'b1000;
    return base >> r;
  endfunction

  task automatic model_reset();
    m_mode = M_SCAN; m_row = 0; m_phase = 0; m_run = 0;
    m_late1 = 4'd0; m_late2 = 4'd0;
    m_cap_row = 4'd0; m_cap_col = 4'd0;
    m_strobe = 1'b0; m_kd = 1'b0; m_key = 8'h00;
  endtask

  task automatic model_accept();
    m_key = {m_cap_row, m_cap_col};
    m_strobe = 1'b1; m_kd = 1'b1; m_mode = M_HELD; m_run = 0;
    m_strobe_total++;
  endtask

  task automatic model_release();
    m_kd = 1'b0; m_row = (m_row + 1) % 4; m_phase = 0; m_mode = M_SCAN;
  endtask

  task automatic model_step(input logic [3:0] c);
    logic [3:0] seen;
    seen = m_late2;
    m_strobe = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if (m_phase < SD - 1) m_phase++;
        else if ($countones(seen) == 1) begin
          m_cap_row = row_code(m_row); m_cap_col = seen; m_run = 0;
          if (DEB_EN) m_mode = M_DEB; else model_accept();
        end else begin
          m_row = (m_row + 1) % 4; m_phase = 0;
        end
      end
      M_DEB: begin
        // Accepted on the edge after DC matching samples.
        if (seen != m_cap_col) begin m_mode = M_SCAN; m_phase = 0; end
        else if (m_run >= DC) model_accept();
        else m_run++;
      end
      M_HELD: begin
        if (DEB_EN) begin
          if (seen != 4'd0) m_run = 0;
          else if (m_run >= DC) model_release();
          else m_run++;
        end else if (seen == 4'd0) model_release();
      end
      default: m_mode = M_SCAN;
    endcase
    m_late2 = m_late1;
    m_late1 = c;
  endtask

  // Cycle checker: advance the model at each edge, compare 1 ns later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!nRst) model_reset();
      else model_step(columns);
      #1;
      check("cycle", {18'd0, rows, strobe, cur_key, key_down},
                     {18'd0, row_code(m_row), m_strobe, m_key, m_kd});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_row_fresh(input logic [3:0] target);
    int n;
    n = 0;
    while (rows == target && n < 64) begin @(negedge clk); n++; end
    while (rows != target && n < 128) begin @(negedge clk); n++; end
    check("row_reached", {28'd0, rows}, {28'd0, target});
  endtask

  typedef struct {
    logic [3:0] row_sel;
    logic [3:0] col;
    int         hold;
    int         exp_strobes;
    logic [7:0] exp_key;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int strobes;
    int n;
    int seg_len;
    int pick;
    int model_before;
    logic [3:0] val;

    tbl[0] = '{4'b0010, 4'b1000, 40, 1, 8'b0010_1000};  // R2 C0
    tbl[1] = '{4'b0001, 4'b0100, 40, 1, 8'b0001_0100};  // R3 C1
    tbl[2] = '{4'b1000, 4'b0001, 40, 1, 8'b1000_0001};  // R0 C3
    tbl[3] = '{4'b0100, 4'b1010, 40, 0, 8'b1000_0001};  // two columns: ignored

    // Reset state
    nRst = 1'b0; columns = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_rows",     {28'd0, rows}, 32'h8);
    check("reset_strobe",   {31'd0, strobe}, 32'd0);
    check("reset_cur_key",  {24'd0, cur_key}, 32'd0);
    check("reset_key_down", {31'd0, key_down}, 32'd0);
    $display("reset: rows=%b strobe=%b cur_key=%h key_down=%b", rows, strobe, cur_key, key_down);

    // Idle scan: each row held SD cycles, rotating R0..R3..R0
    nRst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("idle_rows", {28'd0, rows}, {28'd0, row_code((k / SD) % 4)});
      check("idle_strobe", {31'd0, strobe}, 32'd0);
    end
    $display("idle scan: 20 cycles, rows=%b", rows);

    // Table-driven presses
    for (int i = 0; i < 4; i++) begin
      wait_row_fresh(tbl[i].row_sel);
      columns = tbl[i].col;
      strobes = 0;
      repeat (tbl[i].hold) begin
        @(negedge clk);
        if (strobe) strobes++;
      end
      check("held_key_down", {31'd0, key_down}, {31'd0, (tbl[i].exp_strobes != 0)});
      columns = 4'd0;
      n = 0;
      while (key_down && n < 60) begin
        @(negedge clk);
        if (strobe) strobes++;
        n++;
      end
      check("release_key_down", {31'd0, key_down}, 32'd0);
      repeat (4) begin
        @(negedge clk);
        if (strobe) strobes++;
      end
      check("press_strobes", strobes, tbl[i].exp_strobes);
      check("press_cur_key", {24'd0, cur_key}, {24'd0, tbl[i].exp_key});
      $display("press %0d: row=%b col=%b strobes=%0d cur_key=%b", i, tbl[i].row_sel,
               tbl[i].col, strobes, cur_key);
    end

    // Bounce on R2 C0, toggling every 3 cycles
    wait_row_fresh(4'b0010);
    model_before = m_strobe_total;
    strobes = 0;
    for (int r = 0; r < 5; r++) begin
      columns = 4'b1000;
      repeat (3) begin @(negedge clk); if (strobe) strobes++; end
      columns = 4'd0;
      repeat (3) begin @(negedge clk); if (strobe) strobes++; end
    end
    check("bounce_strobes", strobes, DEB_EN ? 0 : (m_strobe_total - model_before));
    check("bounce_row", {28'd0, rows}, {28'd0, (DEB_EN ? 4'b0010 : row_code(m_row))});
    $display("bounce: strobes=%0d rows=%b", strobes, rows);
    repeat (20) @(negedge clk);

    // Reset during HELD
    wait_row_fresh(4'b0100);
    columns = 4'b0010;
    strobes = 0;
    n = 0;
    while (strobes == 0 && n < 40) begin
      @(negedge clk);
      if (strobe) strobes++;
      n++;
    end
    check("held_strobe_seen", strobes, 1);
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    @(negedge clk);
    check("rst_held_key_down", {31'd0, key_down}, 32'd0);
    check("rst_held_cur_key", {24'd0, cur_key}, 32'd0);
    check("rst_held_rows", {28'd0, rows}, 32'h8);
    columns = 4'd0;
    @(negedge clk);
    nRst = 1'b1;
    strobes = 0;
    repeat (30) begin @(negedge clk); if (strobe) strobes++; end
    check("post_reset_strobes", strobes, 0);
    $display("reset in HELD: cur_key=%h key_down=%b post-reset strobes=%0d", cur_key, key_down, strobes);

    // Randomized column activity
    model_before = m_strobe_total;
    for (int s = 0; s < 150; s++) begin
      seg_len = $urandom_range(30, 1);
      pick = $urandom_range(9, 0);
      if (pick < 5) val = 4'd0;
      else if (pick < 9) val = 4'b0001 << $urandom_range(3, 0);
      else val = 4'($urandom_range(15, 0));
      columns = val;
      repeat (seg_len) @(negedge clk);
    end
    columns = 4'd0;
    repeat (60) @(negedge clk);
    $display("random: 150 segments, model strobes=%0d", m_strobe_total - model_before);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
